// File: rtl/piso_word_serializer.sv
// Framed parallel-to-serial converter: small word FIFO feeding start/data(MSB-first)[/parity] frames.
// Optional even-parity bit is enabled by defining the macro PARITY_EN.
module piso_word_serializer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    input  logic [WIDTH-1:0]             load_data,
    output logic                         load_ready,
    output logic                         serial_data_out,
    output logic                         frame_active,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA
`ifdef PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q;
    logic [BW-1:0]    bitCnt_q;
    logic             serial_q;
    logic             active_q;
`ifdef PARITY_EN
    logic             parity_q;
`endif
    logic             push;
    logic             pop;
    logic             frameDone;
    logic [WIDTH-1:0] headWord;

    assign load_ready      = (count_q < DEPTH_C);
    assign push            = load_valid && load_ready;
    assign headWord        = mem_q[rdPtr_q];
    assign serial_data_out = serial_q;
    assign frame_active    = active_q;
    assign fifo_count      = count_q;

    // frameDone marks the cycles in which the FSM is free to take the next word
    always_comb begin
        frameDone = 1'b0;
        case (state_q)
            IDLE:    frameDone = 1'b1;
`ifdef PARITY_EN
            PARITY:  frameDone = 1'b1;
`else
            DATA:    frameDone = (bitCnt_q == LAST_BIT);
`endif
            default: frameDone = 1'b0;
        endcase
        pop = frameDone && (count_q != '0);
    end

    always_comb begin
        wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Next-frame pop happens in the same edge as the last bit leaves, so frames run back-to-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitCnt_q <= '0;
            serial_q <= 1'b0;
            active_q <= 1'b0;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (frameDone) begin
            if (pop) begin
                state_q  <= START;
                shift_q  <= headWord;
                serial_q <= 1'b1;
                active_q <= 1'b1;
`ifdef PARITY_EN
                parity_q <= ^headWord;
`endif
            end else begin
                state_q  <= IDLE;
                serial_q <= 1'b0;
                active_q <= 1'b0;
            end
        end else begin
            case (state_q)
                START: begin
                    state_q  <= DATA;
                    serial_q <= shift_q[WIDTH-1];
                    shift_q  <= shift_q << 1;
                    bitCnt_q <= '0;
                end
                DATA: begin
                    if (bitCnt_q != LAST_BIT) begin
                        serial_q <= shift_q[WIDTH-1];
                        shift_q  <= shift_q << 1;
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
`ifdef PARITY_EN
                    else begin
                        state_q  <= PARITY;
                        serial_q <= parity_q;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_word_serializer.sv
// Self-checking bench for piso_word_serializer: queue-based frame model plus directed and random traffic.
// Follows the PARITY_EN macro so the same bench covers both builds.
`timescale 1ns/1ps
module tb_piso_word_serializer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef PARITY_EN
    localparam int FL = WIDTH + 2;
`else
    localparam int FL = WIDTH + 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             serial_data_out;
    logic             frame_active;
    logic [CW-1:0]    fifo_count;

    int  checks = 0;
    int  errors = 0;
    bit  compareEn = 1'b0;

    logic [WIDTH-1:0] mFifo[$];
    bit               mBits[$];
    bit               mSerial = 1'b0;
    bit               mActive = 1'b0;

    piso_word_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .load_valid      (load_valid),
        .load_data       (load_data),
        .load_ready      (load_ready),
        .serial_data_out (serial_data_out),
        .frame_active    (frame_active),
        .fifo_count      (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a frame is just a list of bits; when it runs out, the next queued word becomes a new list
    initial begin
        logic [WIDTH-1:0] w;
        bit               doPush;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mFifo.delete();
                mBits.delete();
                mSerial = 1'b0;
                mActive = 1'b0;
            end else begin
                doPush = load_valid && (mFifo.size() < DEPTH);
                if (mBits.size() > 0) begin
                    mSerial = mBits.pop_front();
                    mActive = 1'b1;
                end else if (mFifo.size() > 0) begin
                    w = mFifo.pop_front();
                    for (int i = WIDTH - 1; i >= 0; i--) mBits.push_back(w[i]);
`ifdef PARITY_EN
                    mBits.push_back(^w);
`endif
                    mSerial = 1'b1;
                    mActive = 1'b1;
                end else begin
                    mSerial = 1'b0;
                    mActive = 1'b0;
                end
                if (doPush) mFifo.push_back(load_data);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (compareEn) begin
                checkOutput("serial_data_out", serial_data_out, mSerial);
                checkOutput("frame_active", frame_active, mActive);
                checkOutput("fifo_count", fifo_count, mFifo.size());
                checkOutput("load_ready", load_ready, (mFifo.size() < DEPTH));
            end
        end
    end

    task automatic syncEdge();
        @(posedge clk);
        #1;
    endtask

    // Must be entered 1 ns after a rising edge; returns 1 ns after the accepting edge
    task automatic applyStimulus(input logic [WIDTH-1:0] word, output int stalls);
        bit accepted;
        accepted   = 1'b0;
        stalls     = 0;
        load_valid = 1'b1;
        load_data  = word;
        while (!accepted && stalls < 40) begin
            @(negedge clk);
            accepted = load_ready;
            @(posedge clk);
            #1;
            if (!accepted) stalls++;
        end
        load_valid = 1'b0;
        load_data  = WIDTH'($urandom);
        checks++;
        if (!accepted) begin
            errors++;
            $display("[TB] FAIL push_timeout: word %0d not accepted, expected acceptance within 40 cycles", word);
        end
    endtask

    initial begin
        bit   expSingle[];
        bit   expActive[];
        bit   expB2B[];
        int   st, stA, stB, stC, stD;
        int   peak;
        int   ones;

`ifdef PARITY_EN
        expSingle = '{1, 1, 0, 1, 1, 1, 0};
        expActive = '{1, 1, 1, 1, 1, 1, 0};
        expB2B    = '{1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
`else
        expSingle = '{1, 1, 0, 1, 1, 0};
        expActive = '{1, 1, 1, 1, 1, 0};
        expB2B    = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
`endif

        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        #12.5;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_serial", serial_data_out, 0);
        checkOutput("reset_active", frame_active, 0);
        checkOutput("reset_count", fifo_count, 0);
        checkOutput("reset_ready", load_ready, 1);
        compareEn = 1'b1;

        $display("[TB] single word 1011");
        syncEdge();
        applyStimulus(4'b1011, st);
        @(negedge clk);
        checkOutput("single_count", fifo_count, 1);
        for (int i = 0; i <= FL; i++) begin
            @(negedge clk);
            checkOutput($sformatf("single_bit%0d", i), serial_data_out, expSingle[i]);
            checkOutput($sformatf("single_active%0d", i), frame_active, expActive[i]);
        end
        repeat (3) @(negedge clk);

        $display("[TB] back-to-back 0001, 1000");
        syncEdge();
        applyStimulus(4'b0001, st);
        applyStimulus(4'b1000, st);
        peak = 0;
        for (int i = 0; i < 2 * FL; i++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b_bit%0d", i), serial_data_out, expB2B[i]);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        checkOutput("b2b_peak_count", peak, 1);
        repeat (3) @(negedge clk);

        $display("[TB] full FIFO");
        syncEdge();
        applyStimulus(4'b1100, stA);
        applyStimulus(4'b0110, stB);
        applyStimulus(4'b0011, stC);
        applyStimulus(4'b1001, stD);
        checkOutput("full_stall_third", stC, 0);
        checkOutput("full_stall_fourth", stD, FL - 1);
        repeat (4 * FL + 4) @(negedge clk);

        $display("[TB] reset mid-frame");
        syncEdge();
        applyStimulus(4'b1111, st);
        applyStimulus(4'b1010, st);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("midreset_before", serial_data_out, 1);
        reset = 1'b1;
        #1;
        checkOutput("midreset_serial", serial_data_out, 0);
        checkOutput("midreset_active", frame_active, 0);
        checkOutput("midreset_count", fifo_count, 0);
        checkOutput("midreset_ready", load_ready, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        ones = 0;
        repeat (12) begin
            @(negedge clk);
            if (serial_data_out !== 1'b0 || frame_active !== 1'b0) ones++;
        end
        checkOutput("midreset_no_frame", ones, 0);
        checkOutput("midreset_count_after", fifo_count, 0);

        $display("[TB] wrap-around 0001..0110");
        syncEdge();
        for (int w = 1; w <= 6; w++) begin
            applyStimulus(WIDTH'(w), st);
            @(posedge clk);
            #1;
        end
        repeat (6 * FL + 4) @(negedge clk);

        $display("[TB] random traffic");
        syncEdge();
        repeat (400) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data  = WIDTH'($urandom);
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        repeat (4 * FL + 6) @(negedge clk);
        checkOutput("drain_active", frame_active, 0);
        checkOutput("drain_count", fifo_count, 0);

        compareEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time %0t, expected completion before 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
